// File: rtl/pc_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_trace_buffer
//  Description : PC history buffer for the core debug path. It keeps a
//                registered copy of the last retired PC. It records the last
//                DEPTH retired PCs in a circular buffer. The buffer freezes
//                POST_CNT samples after a PC-match trigger. Entries are read
//                back by age (0 = newest).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_trace_buffer #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [XLEN-1:0]            i_pc,
    input  logic                       i_pc_valid,
    input  logic                       i_trig_en,
    input  logic [XLEN-1:0]            i_trig_pc,
    input  logic                       i_rearm,
    input  logic                       i_rd_en,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
    output logic [XLEN-1:0]            o_pc_debug,
    output logic [XLEN-1:0]            o_rd_data,
    output logic                       o_rd_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [$clog2(DEPTH)-1:0]   o_trig_idx,
    output logic                       o_frozen
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] C_POST_CNT  = CW'(POST_CNT);

    typedef enum logic [1:0] {
        CAPTURE  = 2'd0,
        POSTTRIG = 2'd1,
        FROZEN   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     wr_ptr_nxt;
    logic [CW-1:0]     count_nxt;
    logic [CW-1:0]     post_cnt;
    logic [CW-1:0]     post_cnt_nxt;
    logic [AW-1:0]     trig_idx_nxt;
    logic              wr_en;
    logic              trig_hit;
    logic [AW-1:0]     rd_slot;
    logic              rd_in_range;

    logic [XLEN-1:0]   mem [DEPTH];

    // A sample is stored only while tracing, and never in a rearm cycle.
    // Rearm wins over everything, so the sample in that cycle is dropped.
    assign wr_en = i_pc_valid && !i_rearm && (state != FROZEN);

    // The trigger compares against the full PC width. It is only armed in CAPTURE.
    assign trig_hit = wr_en && (state == CAPTURE) && i_trig_en && (i_pc == i_trig_pc);

    // The age index is converted to a physical slot. The pre-edge write pointer is used.
    assign rd_slot     = wr_ptr - AW'(1) - i_rd_idx;
    assign rd_in_range = ({1'b0, i_rd_idx} < o_count);

    assign o_frozen = (state == FROZEN);

    // This process computes the next state and the next trace bookkeeping values.
    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        count_nxt    = o_count;
        post_cnt_nxt = post_cnt;
        trig_idx_nxt = o_trig_idx;

        if (i_rearm) begin
            state_nxt    = CAPTURE;
            wr_ptr_nxt   = '0;
            count_nxt    = '0;
            post_cnt_nxt = '0;
        end else if (wr_en) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
            if (o_count != C_DEPTH_CNT) begin
                count_nxt = o_count + CW'(1);
            end

            case (state)
                CAPTURE: begin
                    if (trig_hit) begin
                        trig_idx_nxt = wr_ptr;
                        if (POST_CNT == 0) begin
                            state_nxt = FROZEN;
                        end else begin
                            state_nxt    = POSTTRIG;
                            post_cnt_nxt = C_POST_CNT;
                        end
                    end
                end
                POSTTRIG: begin
                    post_cnt_nxt = post_cnt - CW'(1);
                    if (post_cnt == CW'(1)) begin
                        state_nxt = FROZEN;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // This process holds the state and bookkeeping registers. Reset clears the whole trace.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            o_count    <= '0;
            post_cnt   <= '0;
            o_trig_idx <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            o_count    <= count_nxt;
            post_cnt   <= post_cnt_nxt;
            o_trig_idx <= trig_idx_nxt;
        end
    end

    // This process registers the debug PC. It follows every retired PC, even while frozen.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_pc_debug <= '0;
        end else if (i_pc_valid) begin
            o_pc_debug <= i_pc;
        end
    end

    // This process writes the trace RAM. It has no reset, because a zero count hides stale entries.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= i_pc;
        end
    end

    // This process is the read port with 1-cycle latency. It returns pre-write contents
    // on a same-cycle write. An out-of-range request returns zero.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else if (i_rd_en) begin
            o_rd_valid <= rd_in_range;
            o_rd_data  <= rd_in_range ? mem[rd_slot] : '0;
        end else begin
            o_rd_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_trace_buffer
//  Description : Self-checking bench for pc_trace_buffer (XLEN=32, DEPTH=8,
//                POST_CNT=2). It applies a table of directed vectors and a few
//                hand-written reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_trace_buffer;

    localparam int XLEN     = 32;
    localparam int DEPTH    = 8;
    localparam int POST_CNT = 2;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        rearm;
    logic        rd_en;
    logic [2:0]  rd_idx;
    logic [31:0] pc_debug;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [3:0]  count;
    logic [2:0]  trig_idx;
    logic        frozen;

    int n_checks = 0;
    int n_fail   = 0;

    pc_trace_buffer #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .POST_CNT (POST_CNT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_pc       (pc),
        .i_pc_valid (pc_valid),
        .i_trig_en  (trig_en),
        .i_trig_pc  (trig_pc),
        .i_rearm    (rearm),
        .i_rd_en    (rd_en),
        .i_rd_idx   (rd_idx),
        .o_pc_debug (pc_debug),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .o_count    (count),
        .o_trig_idx (trig_idx),
        .o_frozen   (frozen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ten;
        logic [31:0] tpc;
        logic        rearm;
        logic        rd;
        logic [2:0]  idx;
        logic [31:0] e_dbg;
        logic [3:0]  e_cnt;
        logic        e_frz;
        logic        e_rv;
        logic        chk_rd;
        logic [31:0] e_rd;
        logic        chk_t;
        logic [2:0]  e_t;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [31:0] p, logic ten, logic [31:0] tpc,
                                logic ra, logic rd, logic [2:0] idx,
                                logic [31:0] e_dbg, logic [3:0] e_cnt, logic e_frz,
                                logic e_rv, logic chk_rd, logic [31:0] e_rd,
                                logic chk_t, logic [2:0] e_t);
        vec_t r;
        r.v = v; r.pc = p; r.ten = ten; r.tpc = tpc; r.rearm = ra; r.rd = rd; r.idx = idx;
        r.e_dbg = e_dbg; r.e_cnt = e_cnt; r.e_frz = e_frz; r.e_rv = e_rv;
        r.chk_rd = chk_rd; r.e_rd = e_rd; r.chk_t = chk_t; r.e_t = e_t;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic ten,
                         input logic [31:0] tpc, input logic ra, input logic rd,
                         input logic [2:0] idx);
        pc_valid = v; pc = p; trig_en = ten; trig_pc = tpc;
        rearm = ra; rd_en = rd; rd_idx = idx;
    endtask

    initial begin
        int k;
        string tag;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);

        // Reset is held while a valid PC is present. It must be ignored.
        rst = 1'b0;
        drive(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_dbg",   pc_debug, 32'h0);
        check("rst_cnt",   {28'h0, count}, 32'h0);
        check("rst_frz",   {31'h0, frozen}, 32'h0);
        check("rst_rv",    {31'h0, rd_valid}, 32'h0);
        check("rst_rd",    rd_data, 32'h0);
        check("rst_tidx",  {29'h0, trig_idx}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_dbg", pc_debug, 32'h1234_5678);
        check("rel_cnt", {28'h0, count}, 32'h1);

        // Wrap: rearm, then write ten PCs, then read the newest and the oldest entries.
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 32'(4 * i), 0, 0, 0, 0, 0, 32'(4 * i),
                              4'((i + 1 > 8) ? 8 : i + 1), 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h24, 8, 0, 1, 1, 32'h24, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7, 32'h24, 8, 0, 1, 1, 32'h08, 0, 0));
        // Trigger: rearm first. rd_data must hold while there is no request.
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h24, 0, 0, 0, 1, 32'h08, 0, 0));
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(1, 32'(4 * i), 1, 32'h10, 0, 0, 0, 32'(4 * i),
                              4'((i > 6) ? 7 : i + 1), (i >= 6), 0, 0, 0, (i >= 4), 3'd4));
        vecs.push_back(mk(0, 0, 1, 32'h10, 0, 1, 0, 32'h20, 7, 1, 1, 1, 32'h18, 1, 3'd4));
        // Empty and out-of-range reads.
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 32'h100, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h104, 0, 0, 0, 0, 0, 32'h104, 2, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h108, 0, 0, 0, 0, 0, 32'h108, 3, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 32'h108, 3, 0, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 32'h108, 3, 0, 1, 1, 32'h100, 0, 0));
        // A read and a write in the same cycle. The read returns pre-write contents.
        vecs.push_back(mk(1, 32'h10C, 0, 0, 0, 1, 0, 32'h10C, 4, 0, 1, 1, 32'h108, 0, 0));
        // Rearm with a matching valid PC: the PC is not stored and does not trigger.
        vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 0, 0, 32'h40, 0, 0, 0, 0, 0, 1, 3'd4));
        vecs.push_back(mk(1, 32'h44, 1, 32'h40, 0, 0, 0, 32'h44, 1, 0, 0, 0, 0, 1, 3'd4));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].pc, vecs[i].ten, vecs[i].tpc,
                  vecs[i].rearm, vecs[i].rd, vecs[i].idx);
            @(posedge clk);
            #1;
            tag = $sformatf("v%0d", i);
            check({tag, "_dbg"}, pc_debug, vecs[i].e_dbg);
            check({tag, "_cnt"}, {28'h0, count}, {28'h0, vecs[i].e_cnt});
            check({tag, "_frz"}, {31'h0, frozen}, {31'h0, vecs[i].e_frz});
            check({tag, "_rv"},  {31'h0, rd_valid}, {31'h0, vecs[i].e_rv});
            if (vecs[i].chk_rd)
                check({tag, "_rd"}, rd_data, vecs[i].e_rd);
            if (vecs[i].chk_t)
                check({tag, "_tidx"}, {29'h0, trig_idx}, {29'h0, vecs[i].e_t});
        end

        // Async reset in the middle of POSTTRIG. State is CAPTURE with count=1 and wr_ptr=1.
        @(negedge clk);
        drive(1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 1'b1, 3'd0);
        @(posedge clk);
        #1;
        check("pt_tidx", {29'h0, trig_idx}, 32'h1);
        check("pt_rd",   rd_data, 32'h44);
        @(negedge clk);
        drive(1'b1, 32'h204, 1'b1, 32'h200, 1'b0, 1'b0, 3'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("ar_dbg",  pc_debug, 32'h0);
        check("ar_cnt",  {28'h0, count}, 32'h0);
        check("ar_tidx", {29'h0, trig_idx}, 32'h0);
        check("ar_rd",   rd_data, 32'h0);
        check("ar_rv",   {31'h0, rd_valid}, 32'h0);
        check("ar_frz",  {31'h0, frozen}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
        // In CAPTURE, two non-matching writes must not freeze the buffer.
        // A leftover POSTTRIG counter would freeze it.
        k = 0;
        repeat (2) begin
            @(negedge clk);
            drive(1'b1, 32'h300 + 32'(4 * k), 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
            @(posedge clk);
            #1;
            k++;
        end
        check("post_rst_cnt", {28'h0, count}, 32'h2);
        check("post_rst_frz", {31'h0, frozen}, 32'h0);
        check("post_rst_dbg", pc_debug, 32'h304);

        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
